// File: rtl/common_sync_fifo.sv
// Single-clock valid/ready FIFO with registered head word, fill level,
// almost-full flag and synchronous flush.
module common_sync_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_THR = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic [DATA_W-1:0] r_mdata;

  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rd_inc;
  logic [LW-1:0]     w_level_nxt;
  logic [DATA_W-1:0] w_mdata_nxt;

  assign w_push   = s_valid && !r_full;
  assign w_pop    = !r_empty && m_ready;
  assign w_rd_inc = r_rd_ptr + AW'(1);

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // The head register is loaded with whatever word becomes the head after
  // this edge; when the FIFO holds one word, the next head is the word being
  // written this same edge, so it comes from s_data rather than storage.
  always_comb begin
    w_mdata_nxt = r_mdata;
    if (flush) begin
      w_mdata_nxt = '0;
    end else if (w_pop) begin
      if (r_level == LW'(1)) begin
        if (w_push) w_mdata_nxt = s_data;
      end else begin
        w_mdata_nxt = r_mem[w_rd_inc];
      end
    end else if (r_empty && w_push) begin
      w_mdata_nxt = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_mdata  <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= w_rd_inc;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_afull <= (w_level_nxt >= LW'(AFULL_THR));
      r_mdata <= w_mdata_nxt;
    end
  end

  assign s_ready     = !r_full;
  assign m_valid     = !r_empty;
  assign m_data      = r_mdata;
  assign level       = r_level;
  assign almost_full = r_afull;
  assign empty       = r_empty;
  assign full        = r_full;

endmodule

// File: tb/tb_common_sync_fifo.sv
// Directed bench for common_sync_fifo (DATA_W=8, DEPTH=16, AFULL_THR=14).
module tb_common_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] level;
  logic       almost_full;
  logic       empty;
  logic       full;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  common_sync_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_THR(14)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .almost_full(almost_full), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".afull"}, 32'(almost_full), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // reset held for 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("rst");
      chk("rst.m_data", 32'(m_data), 32'h0);
    end
    rst_n = 1'b1;
    step();
    step();
    chk_idle("idle");

    // fill 0x01..0x10 with consumer stalled
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      chk("fill.level", 32'(level), 32'(i));
      chk("fill.afull", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
      chk("fill.full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
      chk("fill.s_ready", 32'(s_ready), (i == 16) ? 32'd0 : 32'd1);
      chk("fill.m_data", 32'(m_data), 32'h01);
    end
    // 17th word held off
    s_data = 8'h11;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold.level", 32'(level), 32'd16);
      chk("hold.s_ready", 32'(s_ready), 32'd0);
    end

    // pop while full with a push pending: push must not land this cycle
    s_data  = 8'hEE;
    m_ready = 1'b1;
    chk("fullpop.m_data", 32'(m_data), 32'h01);
    step();
    s_valid = 1'b0;
    chk("fullpop.level", 32'(level), 32'd15);
    chk("fullpop.s_ready", 32'(s_ready), 32'd1);

    // drain remaining 0x02..0x10 on consecutive cycles
    for (int i = 2; i <= 16; i++) begin
      chk("drain.m_valid", 32'(m_valid), 32'd1);
      chk("drain.m_data", 32'(m_data), 32'(i));
      step();
    end
    m_ready = 1'b0;
    chk_idle("drained");

    // latency into empty FIFO
    s_valid = 1'b1;
    s_data  = 8'hA5;
    chk("lat.before", 32'(m_valid), 32'd0);
    step();
    s_valid = 1'b0;
    chk("lat.m_valid", 32'(m_valid), 32'd1);
    chk("lat.m_data", 32'(m_data), 32'hA5);
    chk("lat.level", 32'(level), 32'd1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("lat.empty", 32'(empty), 32'd1);

    // level 5, then 20 cycles of simultaneous push/pop
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h20 + i);
      step();
    end
    chk("pp.level0", 32'(level), 32'd5);
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data = 8'(8'h25 + k);
      chk("pp.m_data", 32'(m_data), 32'(8'h20 + k));
      step();
      chk("pp.level", 32'(level), 32'd5);
    end
    s_valid = 1'b0;
    for (int k = 20; k < 25; k++) begin
      chk("pp.tail", 32'(m_data), 32'(8'h20 + k));
      step();
    end
    m_ready = 1'b0;
    chk("pp.empty", 32'(empty), 32'd1);

    // flush at level 7 with a handshake active
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + i);
      step();
    end
    chk("fl.level7", 32'(level), 32'd7);
    flush   = 1'b1;
    s_data  = 8'h99;
    m_ready = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("fl.level", 32'(level), 32'd0);
    chk("fl.m_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'h50;
    step();
    s_valid = 1'b0;
    chk("fl.next", 32'(m_data), 32'h50);
    chk("fl.next_level", 32'(level), 32'd1);

    // asynchronous reset mid-burst, between clock edges
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'h60 + i);
      step();
    end
    chk("ar.level_before", 32'(level), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("ar");
    chk("ar.m_data", 32'(m_data), 32'h0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("ar.after");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
